// File: rtl/io_panel.sv
`default_nettype none
// ============================================================================
// Module   : io_panel
// Purpose  : Memory-mapped front panel for the CPU data bus. Four writable
//            LED digit registers (0xFC-0xFF) are scanned onto an active-low
//            4-digit 7-segment display, and three synchronised, debounced
//            push buttons are readable at 0xFB.
// Revision : 1.0 - initial release
// ============================================================================
module io_panel #(
  parameter logic [15:0] SCAN_DIV   = 16'd50000,
  parameter logic [19:0] DEB_CYCLES = 20'd500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  input  logic       we,
  output logic [7:0] rdata,
  input  logic [2:0] btn,
  output logic [7:0] seg_n,
  output logic [3:0] an_n
);

  localparam logic [7:0]  ADDR_BTN  = 8'hFB;
  localparam logic [5:0]  DIG_PAGE  = 6'b111111;   // addresses 0xFC..0xFF
  localparam logic [15:0] SCAN_LAST = SCAN_DIV - 16'd1;
  // The cycle in which a new candidate is captured is already the first
  // stable cycle, so the terminal count is two below DEB_CYCLES. This makes
  // deb change exactly DEB_CYCLES cycles after sync last changed.
  localparam logic [19:0] DEB_LAST  = DEB_CYCLES - 20'd2;

  logic [3:0][7:0] digit;
  logic [2:0]      sync1;
  logic [2:0]      sync2;
  logic [2:0]      cand;
  logic [2:0]      deb;
  logic [19:0]     deb_cnt;
  logic [15:0]     scan_cnt;
  logic [1:0]      idx;

  // Digit registers: stores to 0xFC..0xFF land in D0..D3.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit <= {4{8'hFF}};
    end else if (we && (addr[7:2] == DIG_PAGE)) begin
      digit[addr[1:0]] <= wdata;
    end
  end

  // Two-flop synchroniser for the asynchronous button inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 3'b000;
      sync2 <= 3'b000;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

  // Vector debouncer: deb follows sync only after it has been stable long enough.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand    <= 3'b000;
      deb     <= 3'b000;
      deb_cnt <= 20'd0;
    end else if (sync2 != cand) begin
      cand    <= sync2;
      deb_cnt <= 20'd0;
    end else if (deb_cnt == DEB_LAST) begin
      deb     <= cand;
    end else begin
      deb_cnt <= deb_cnt + 20'd1;
    end
  end

  // Scan timer: dwell SCAN_DIV cycles per digit, then advance the index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= 16'd0;
      idx      <= 2'd0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt <= 16'd0;
      idx      <= idx + 2'd1;
    end else begin
      scan_cnt <= scan_cnt + 16'd1;
    end
  end

  // Registered display drive: anode and segments always update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_n <= 8'hFF;
      an_n  <= 4'b1111;
    end else begin
      an_n  <= ~(4'b0001 << idx);
      seg_n <= digit[idx];
    end
  end

  // Zero-wait-state read decode; only the button page returns data.
  always_comb begin
    rdata = 8'h00;
    if (addr == ADDR_BTN) begin
      rdata = {5'b00000, deb};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_io_panel.sv
`default_nettype none
// ============================================================================
// Module   : tb_io_panel
// Purpose  : Self-checking bench for io_panel (SCAN_DIV = 4, DEB_CYCLES = 8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_io_panel;

  localparam int LAT = 10;   // 2 sync stages + 8 stable cycles

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] addr  = 8'hFB;
  logic [7:0] wdata = 8'h00;
  logic       we    = 1'b0;
  logic [2:0] btn   = 3'b000;
  logic [7:0] rdata;
  logic [7:0] seg_n;
  logic [3:0] an_n;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  rd_q[$];
  logic [11:0] disp_q[$];
  logic [7:0]  model_dig [4];

  always #5 clk = ~clk;

  io_panel #(
    .SCAN_DIV  (16'd4),
    .DEB_CYCLES(20'd8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .addr (addr),
    .wdata(wdata),
    .we   (we),
    .rdata(rdata),
    .btn  (btn),
    .seg_n(seg_n),
    .an_n (an_n)
  );

  // Single-cycle store issued from a negedge; leaves us on the next negedge.
  task automatic write_reg(input logic [7:0] a, input logic [7:0] d);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    @(negedge clk);
    we    = 1'b0;
    addr  = 8'hFB;
    if (a[7:2] == 6'b111111) model_dig[a[1:0]] = d;
  endtask

  // Wait for the first cycle of the digit-0 window (bounded).
  task automatic align_idx0(output bit ok);
    for (int t = 0; t < 40 && an_n !== 4'b0111; t++) @(negedge clk);
    for (int t = 0; t < 40 && an_n !== 4'b1110; t++) @(negedge clk);
    ok = (an_n === 4'b1110);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({seg_n, an_n, rdata} !== {8'hFF, 4'b1111, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_hold: seg_n=%h an_n=%b rdata=%h required FF 1111 00", seg_n, an_n, rdata);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({an_n, seg_n} !== {4'b1110, 8'hFF}) begin
      n_fail++;
      $display("FAIL reset_first_edge: an_n=%b seg_n=%h required 1110 FF", an_n, seg_n);
    end
    @(negedge clk);
    repeat (5) @(negedge clk);
    write_reg(8'hFC, 8'h12);
    repeat (3) @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({seg_n, an_n, rdata} !== {8'hFF, 4'b1111, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_async: seg_n=%h an_n=%b rdata=%h required FF 1111 00", seg_n, an_n, rdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) model_dig[i] = 8'hFF;
    @(posedge clk); #1;
    n_checks++;
    if ({an_n, seg_n} !== {4'b1110, 8'hFF}) begin
      n_fail++;
      $display("FAIL reset_mid_release: an_n=%b seg_n=%h required 1110 FF", an_n, seg_n);
    end
    @(negedge clk);
  endtask

  task automatic test_scan;
    bit ok;
    logic [11:0] exp, act;
    write_reg(8'hFF, 8'hC0);
    write_reg(8'hFE, 8'hF9);
    write_reg(8'hFD, 8'hFF);
    write_reg(8'hFC, 8'hA4);
    write_reg(8'h80, 8'h00);
    write_reg(8'hFB, 8'h55);
    align_idx0(ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL scan_align: an_n=%b required 1110", an_n);
    end
    for (int r = 0; r < 2; r++)
      for (int d = 0; d < 4; d++)
        for (int k = 0; k < 4; k++)
          disp_q.push_back({~(4'b0001 << d), model_dig[d]});
    while (disp_q.size() > 0) begin
      exp = disp_q.pop_front();
      act = {an_n, seg_n};
      n_checks++;
      if (act !== exp) begin
        n_fail++;
        $display("FAIL scan_order: an_n/seg_n=%b/%h required %b/%h", act[11:8], act[7:0], exp[11:8], exp[7:0]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_live_update;
    bit ok;
    logic [11:0] exp, act;
    align_idx0(ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL live_align: an_n=%b required 1110", an_n);
    end
    disp_q.push_back({4'b1110, 8'hA4});
    disp_q.push_back({4'b1110, 8'h99});
    disp_q.push_back({4'b1110, 8'h99});
    for (int d = 1; d < 4; d++)
      for (int k = 0; k < 4; k++)
        disp_q.push_back({~(4'b0001 << d), model_dig[d]});
    write_reg(8'hFC, 8'h99);
    while (disp_q.size() > 0) begin
      exp = disp_q.pop_front();
      act = {an_n, seg_n};
      n_checks++;
      if (act !== exp) begin
        n_fail++;
        $display("FAIL live_update: an_n/seg_n=%b/%h required %b/%h", act[11:8], act[7:0], exp[11:8], exp[7:0]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_debounce;
    logic [7:0] exp;
    btn = 3'b100;
    for (int i = 1; i < LAT; i++) rd_q.push_back(8'h00);
    repeat (4) rd_q.push_back(8'h04);
    while (rd_q.size() > 0) begin
      exp = rd_q.pop_front();
      @(negedge clk);
      n_checks++;
      if (rdata !== exp) begin
        n_fail++;
        $display("FAIL debounce_press: rdata=%h required %h", rdata, exp);
      end
    end
    addr = 8'hFA; #1;
    n_checks++;
    if (rdata !== 8'h00) begin
      n_fail++;
      $display("FAIL read_other_addr: rdata=%h required 00", rdata);
    end
    addr = 8'hFB; we = 1'b1; wdata = 8'hFF; #1;
    n_checks++;
    if (rdata !== 8'h04) begin
      n_fail++;
      $display("FAIL read_with_we: rdata=%h required 04", rdata);
    end
    we = 1'b0;
    btn = 3'b010;
    repeat (20) rd_q.push_back(8'h04);
    for (int i = 0; rd_q.size() > 0; i++) begin
      if (i == 5) btn = 3'b100;
      exp = rd_q.pop_front();
      @(negedge clk);
      n_checks++;
      if (rdata !== exp) begin
        n_fail++;
        $display("FAIL debounce_glitch: rdata=%h required %h", rdata, exp);
      end
    end
    btn = 3'b110;
    for (int i = 1; i < LAT; i++) rd_q.push_back(8'h04);
    repeat (3) rd_q.push_back(8'h06);
    while (rd_q.size() > 0) begin
      exp = rd_q.pop_front();
      @(negedge clk);
      n_checks++;
      if (rdata !== exp) begin
        n_fail++;
        $display("FAIL debounce_two_btn: rdata=%h required %h", rdata, exp);
      end
    end
    btn = 3'b000;
    for (int i = 1; i < LAT; i++) rd_q.push_back(8'h06);
    repeat (3) rd_q.push_back(8'h00);
    while (rd_q.size() > 0) begin
      exp = rd_q.pop_front();
      @(negedge clk);
      n_checks++;
      if (rdata !== exp) begin
        n_fail++;
        $display("FAIL debounce_release: rdata=%h required %h", rdata, exp);
      end
    end
  endtask

  task automatic test_bounce;
    logic [7:0] exp;
    repeat (30) rd_q.push_back(8'h00);
    for (int i = 1; i < LAT; i++) rd_q.push_back(8'h00);
    repeat (4) rd_q.push_back(8'h04);
    for (int i = 0; rd_q.size() > 0; i++) begin
      if (i < 30) btn = ((i / 3) % 2 == 0) ? 3'b100 : 3'b000;
      else        btn = 3'b100;
      exp = rd_q.pop_front();
      @(negedge clk);
      n_checks++;
      if (rdata !== exp) begin
        n_fail++;
        $display("FAIL bounce: cycle %0d rdata=%h required %h", i, rdata, exp);
      end
    end
  endtask

  task automatic test_reset_mid_debounce;
    logic [7:0] exp;
    btn = 3'b000;
    for (int i = 1; i < LAT; i++) rd_q.push_back(8'h04);
    repeat (2) rd_q.push_back(8'h00);
    btn = 3'b100;
    // settle to 00 first, then hold 100 for six cycles
    btn = 3'b000;
    while (rd_q.size() > 0) begin
      exp = rd_q.pop_front();
      @(negedge clk);
      n_checks++;
      if (rdata !== exp) begin
        n_fail++;
        $display("FAIL mid_rst_settle: rdata=%h required %h", rdata, exp);
      end
    end
    btn = 3'b100;
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (rdata !== 8'h00) begin
      n_fail++;
      $display("FAIL mid_rst_assert: rdata=%h required 00", rdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i < LAT; i++) rd_q.push_back(8'h00);
    repeat (3) rd_q.push_back(8'h04);
    while (rd_q.size() > 0) begin
      exp = rd_q.pop_front();
      @(negedge clk);
      n_checks++;
      if (rdata !== exp) begin
        n_fail++;
        $display("FAIL mid_rst_latency: rdata=%h required %h", rdata, exp);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) model_dig[i] = 8'hFF;
    @(negedge clk);
    test_reset();
    test_scan();
    test_live_update();
    test_debounce();
    test_bounce();
    test_reset_mid_debounce();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
